// File: rtl/wb_sram_mp.sv
// wb_sram_mp: several Wishbone slave ports in front of one single-port SRAM.
// A round-robin arbiter picks one port per transaction and a small FSM runs
// single accesses and incrementing (linear or wrapping) bursts against the macro.

// sram_sp: single-port synchronous SRAM with byte-lane write enables.
module sram_sp #(
   parameter int    WORDS         = 1024,
   parameter int    AW            = 10,
   parameter int    DW            = 32,
   parameter string MEM_FILE      = "sram.vmem",
   parameter string MEM_IMPL_TYPE = "PLAIN"
) (
   input  logic            clk,
   input  logic            ce,
   input  logic            we,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   din,
   input  logic [DW/8-1:0] sel,
   output logic [DW-1:0]   dout
);
   localparam int SW = DW / 8;
   // Block-RAM primitives run read-first, so dout also refreshes during writes.
   localparam bit READ_ON_WRITE = (MEM_IMPL_TYPE == "XILINX_SPARTAN6");

   logic [DW-1:0] mem [WORDS];

   // Named scope that external simulation loaders target when a file is set.
   if (MEM_FILE != "") begin : g_init_scope
   end

   // Byte-lane writes and registered reads; contents have no reset.
   always_ff @(posedge clk) begin
      if (ce) begin
         if (we) begin
            for (int b = 0; b < SW; b++) begin
               if (sel[b]) mem[addr][b*8 +: 8] <= din[b*8 +: 8];
            end
         end
         if (!we || READ_ON_WRITE) dout <= mem[addr];
      end
   end
endmodule

module wb_sram_mp #(
   parameter int    MEM_SIZE      = 'h4000,
   parameter string MEM_FILE      = "sram.vmem",
   parameter int    AW            = $clog2(MEM_SIZE),
   parameter int    DW            = 32,
   parameter int    PORTS         = 2,
   parameter string MEM_IMPL_TYPE = "PLAIN"
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic [PORTS*AW-1:0]     wb_adr_i,
   input  logic [PORTS*DW-1:0]     wb_dat_i,
   input  logic [PORTS*(DW/8)-1:0] wb_sel_i,
   input  logic [PORTS*3-1:0]      wb_cti_i,
   input  logic [PORTS*2-1:0]      wb_bte_i,
   input  logic [PORTS-1:0]        wb_cyc_i,
   input  logic [PORTS-1:0]        wb_stb_i,
   input  logic [PORTS-1:0]        wb_we_i,
   output logic [PORTS-1:0]        wb_ack_o,
   output logic [PORTS-1:0]        wb_err_o,
   output logic [PORTS-1:0]        wb_rty_o,
   output logic [PORTS*DW-1:0]     wb_dat_o
);
   localparam int SW      = DW / 8;
   localparam int BYTE_AW = SW >> 1;
   localparam int WORD_AW = AW - BYTE_AW;
   localparam int WORDS   = (MEM_SIZE + SW - 1) / SW;
   localparam int GW      = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_SIZE);

   typedef enum logic [2:0] {IDLE, WBUSY, RSTART, RACK, ERR} state_t;

   state_t             state, state_nxt;
   logic [GW-1:0]      grant, grant_nxt;   // doubles as last_grant while IDLE
   logic [WORD_AW-1:0] badr, badr_nxt;

   logic [PORTS-1:0]   req;
   logic               arb_hit;
   logic [GW-1:0]      arb_idx;
   logic [GW-1:0]      cand;
   logic [AW-1:0]      win_adr;
   logic               win_we;
   logic               oor;

   logic               g_cyc, g_stb;
   logic [2:0]         g_cti;
   logic [1:0]         g_bte;
   logic [DW-1:0]      g_dat;
   logic [SW-1:0]      g_sel;

   logic [PORTS-1:0]   ack, err;
   logic               mem_ce, mem_we;
   logic [WORD_AW-1:0] mem_addr;
   logic [DW-1:0]      mem_dout;

   // Next burst address: linear wraps at the full word space, wrap-4/8/16
   // only touch the low 2/3/4 bits.
   function automatic logic [WORD_AW-1:0] advance(input logic [WORD_AW-1:0] a,
                                                  input logic [1:0] bte);
      logic [WORD_AW-1:0] inc;
      logic [WORD_AW-1:0] mask;
      inc = a + WORD_AW'(1);
      case (bte)
         2'b01:   mask = WORD_AW'(3);
         2'b10:   mask = WORD_AW'(7);
         2'b11:   mask = WORD_AW'(15);
         default: mask = '1;
      endcase
      return (a & ~mask) | (inc & mask);
   endfunction

   assign req = wb_cyc_i & wb_stb_i;

   // Round-robin search starting one past the last granted port.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      cand    = '0;
      for (int i = 1; i <= PORTS; i++) begin
         cand = GW'((int'(grant) + i) % PORTS);
         if (!arb_hit && req[cand]) begin
            arb_hit = 1'b1;
            arb_idx = cand;
         end
      end
      win_adr = wb_adr_i[int'(arb_idx)*AW +: AW];
      win_we  = wb_we_i[arb_idx];
   end

   assign oor = ({1'b0, win_adr} >= MEM_LIMIT);

   // Signals of the port that currently owns the SRAM.
   always_comb begin
      g_cyc = wb_cyc_i[grant];
      g_stb = wb_stb_i[grant];
      g_cti = wb_cti_i[int'(grant)*3 +: 3];
      g_bte = wb_bte_i[int'(grant)*2 +: 2];
      g_dat = wb_dat_i[int'(grant)*DW +: DW];
      g_sel = wb_sel_i[int'(grant)*SW +: SW];
   end

   // FSM next state, SRAM control and ack/err decode.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      badr_nxt  = badr;
      ack       = '0;
      err       = '0;
      mem_ce    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = badr;
      unique case (state)
         IDLE: begin
            if (arb_hit) begin
               grant_nxt = arb_idx;
               badr_nxt  = WORD_AW'(win_adr >> BYTE_AW);
               if (oor)         state_nxt = ERR;
               else if (win_we) state_nxt = WBUSY;
               else             state_nxt = RSTART;
            end
         end
         WBUSY: begin
            if (!g_cyc) begin
               state_nxt = IDLE;
            end else if (g_stb) begin
               ack[grant] = 1'b1;
               mem_ce     = 1'b1;
               mem_we     = 1'b1;
               if (g_cti == 3'b010) badr_nxt  = advance(badr, g_bte);
               else                 state_nxt = IDLE;
            end
         end
         RSTART: begin
            if (!g_cyc) begin
               state_nxt = IDLE;
            end else if (g_stb) begin
               mem_ce    = 1'b1;
               state_nxt = RACK;
            end
         end
         RACK: begin
            if (!g_cyc) begin
               state_nxt = IDLE;
            end else if (!g_stb) begin
               // the prefetched word is dropped and re-read once stb returns
               state_nxt = RSTART;
            end else begin
               ack[grant] = 1'b1;
               if (g_cti == 3'b010) begin
                  badr_nxt = advance(badr, g_bte);
                  mem_ce   = 1'b1;
                  mem_addr = badr_nxt;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         ERR: begin
            if (g_cyc) err[grant] = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, grant and burst address registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
         grant <= GW'(PORTS - 1);
         badr  <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         badr  <= badr_nxt;
      end
   end

   sram_sp #(
      .WORDS         (WORDS),
      .AW            (WORD_AW),
      .DW            (DW),
      .MEM_FILE      (MEM_FILE),
      .MEM_IMPL_TYPE (MEM_IMPL_TYPE)
   ) u_sram (
      .clk  (wb_clk_i),
      .ce   (mem_ce),
      .we   (mem_we),
      .addr (mem_addr),
      .din  (g_dat),
      .sel  (g_sel),
      .dout (mem_dout)
   );

   assign wb_ack_o = ack;
   assign wb_err_o = err;
   assign wb_rty_o = '0;
   assign wb_dat_o = {PORTS{mem_dout}};
endmodule

// File: tb/tb_wb_sram_mp.sv
// tb_wb_sram_mp: directed bench for wb_sram_mp (2 ports, 32-bit, MEM_SIZE 'h3000).
module tb_wb_sram_mp;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [27:0] adr = '0;
   logic [63:0] dat_i = '0;
   logic [7:0]  sel = '0;
   logic [5:0]  cti = '0;
   logic [3:0]  bte = '0;
   logic [1:0]  cyc = '0, stb = '0, we = '0;
   logic [1:0]  ack, err, rty;
   logic [63:0] dat_o;

   int          n_cmp = 0;
   int          n_bad = 0;

   logic [31:0] bdat [8];
   int          back [8];
   logic [31:0] brd  [8];
   int          bbeats;

   typedef struct {
      int          p;
      bit          w;
      logic [13:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int          lat;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [12];

   wb_sram_mp #(.MEM_SIZE('h3000), .DW(32), .PORTS(2)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb_adr_i (adr),
      .wb_dat_i (dat_i),
      .wb_sel_i (sel),
      .wb_cti_i (cti),
      .wb_bte_i (bte),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_ack_o (ack),
      .wb_err_o (err),
      .wb_rty_o (rty),
      .wb_dat_o (dat_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic set_port(input int p, input bit on, input bit w, input logic [13:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] c, input logic [1:0] b);
      cyc[p] = on;
      stb[p] = on;
      we[p]  = w;
      adr[p*14 +: 14] = a;
      dat_i[p*32 +: 32] = d;
      sel[p*4 +: 4] = s;
      cti[p*3 +: 3] = c;
      bte[p*2 +: 2] = b;
   endtask

   // Runs an n-beat transaction on port p; called in the cycle the request
   // should first be seen (cycle 0). Ack cycles land in back[], read data in brd[].
   task automatic burst(input int p, input bit w, input logic [13:0] a,
                        input logic [3:0] s, input logic [1:0] b, input int n);
      int c;
      for (int i = 0; i < 8; i++) begin
         back[i] = -1;
         brd[i]  = 'x;
      end
      bbeats = 0;
      c = 0;
      set_port(p, 1'b1, w, a, bdat[0], s, (n == 1) ? 3'b111 : 3'b010, b);
      while (bbeats < n && c < 40) begin
         @(posedge clk); #1;
         c++;
         dat_i[p*32 +: 32] = bdat[bbeats];
         cti[p*3 +: 3] = (bbeats == n - 1) ? 3'b111 : 3'b010;
         @(negedge clk);
         if (ack[p]) begin
            back[bbeats] = c;
            brd[bbeats]  = dat_o[p*32 +: 32];
            bbeats++;
         end
      end
      @(posedge clk); #1;
      set_port(p, 1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00);
   endtask

   task automatic check_burst(input string nm, input int n, input int first, input bit chk_data);
      check({nm, " beats"}, 32'(bbeats), 32'(n));
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s ack%0d cycle", nm, i), 32'(back[i]), 32'(first + i));
         if (chk_data) check($sformatf("%s beat%0d data", nm, i), brd[i], bdat[i]);
      end
   endtask

   // Both ports issue single reads (p0 @0x10, p1 @0x100); returns after nacks acks.
   task automatic dual_reads(input string nm, input int nacks);
      int k;
      logic [31:0] want;
      k = 0;
      set_port(0, 1'b1, 1'b0, 14'h0010, '0, 4'hF, 3'b000, 2'b00);
      set_port(1, 1'b1, 1'b0, 14'h0100, '0, 4'hF, 3'b000, 2'b00);
      for (int c = 0; c < 40 && k < nacks; c++) begin
         @(negedge clk);
         if (ack != 2'b00) begin
            want = (k % 2 == 0) ? 32'h0000BEEF : 32'h12345678;
            check($sformatf("%s ack%0d port", nm, k), 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("%s ack%0d cycle", nm, k), 32'(c), 32'(2 + 3 * k));
            check($sformatf("%s ack%0d data", nm, k), dat_o[(k % 2)*32 +: 32], want);
            k++;
         end
      end
      check({nm, " ack count"}, 32'(k), 32'(nacks));
      @(posedge clk); #1;
      set_port(0, 1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00);
      set_port(1, 1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int errs, acks;

      tbl[0]  = '{0, 1'b1, 14'h0010, 32'h00000000, 4'hF, 1, 32'h0};
      tbl[1]  = '{0, 1'b1, 14'h0010, 32'hDEADBEEF, 4'h3, 1, 32'h0};
      tbl[2]  = '{0, 1'b0, 14'h0010, 32'h0,        4'hF, 2, 32'h0000BEEF};
      tbl[3]  = '{1, 1'b1, 14'h0100, 32'h12345678, 4'hF, 1, 32'h0};
      tbl[4]  = '{1, 1'b0, 14'h0100, 32'h0,        4'hF, 2, 32'h12345678};
      tbl[5]  = '{1, 1'b1, 14'h0104, 32'h11223344, 4'hF, 1, 32'h0};
      tbl[6]  = '{0, 1'b1, 14'h0104, 32'hAABBCCDD, 4'h8, 1, 32'h0};
      tbl[7]  = '{0, 1'b0, 14'h0104, 32'h0,        4'hF, 2, 32'hAA223344};
      tbl[8]  = '{1, 1'b1, 14'h2FFC, 32'hCAFEF00D, 4'hF, 1, 32'h0};
      tbl[9]  = '{1, 1'b0, 14'h2FFC, 32'h0,        4'hF, 2, 32'hCAFEF00D};
      tbl[10] = '{0, 1'b1, 14'h0004, 32'h0BADF00D, 4'hF, 1, 32'h0};
      tbl[11] = '{0, 1'b0, 14'h0004, 32'h0,        4'hF, 2, 32'h0BADF00D};

      // reset state
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset ack", 32'(ack), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset rty", 32'(rty), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // single accesses from the table
      for (int i = 0; i < 12; i++) begin
         bdat[0] = tbl[i].d;
         burst(tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].s, 2'b00, 1);
         check($sformatf("vec%0d ack cycle", i), 32'(back[0]), 32'(tbl[i].lat));
         if (!tbl[i].w) check($sformatf("vec%0d read data", i), brd[0], tbl[i].exp);
      end

      // linear write burst on port 1 (word i = i for words 8..11), then read back
      for (int i = 0; i < 4; i++) bdat[i] = 32'(8 + i);
      burst(1, 1'b1, 14'h0020, 4'hF, 2'b00, 4);
      check_burst("lin wr", 4, 1, 1'b0);
      burst(1, 1'b0, 14'h0020, 4'hF, 2'b00, 4);
      check_burst("lin rd", 4, 2, 1'b1);

      // wrap-4 write burst from word 14 on port 0
      bdat[0] = 32'hA1A1A1A1; bdat[1] = 32'hB2B2B2B2;
      bdat[2] = 32'hC3C3C3C3; bdat[3] = 32'hD4D4D4D4;
      burst(0, 1'b1, 14'h0038, 4'hF, 2'b01, 4);
      check_burst("wrap wr", 4, 1, 1'b0);
      burst(0, 1'b0, 14'h0038, 4'hF, 2'b00, 1);
      check("wrap word14", brd[0], 32'hA1A1A1A1);
      burst(0, 1'b0, 14'h003C, 4'hF, 2'b00, 1);
      check("wrap word15", brd[0], 32'hB2B2B2B2);
      burst(0, 1'b0, 14'h0030, 4'hF, 2'b00, 1);
      check("wrap word12", brd[0], 32'hC3C3C3C3);
      burst(0, 1'b0, 14'h0034, 4'hF, 2'b00, 1);
      check("wrap word13", brd[0], 32'hD4D4D4D4);

      // wrap-4 read burst from word 15 on port 1: words 15,12,13,14
      bdat[0] = 32'hB2B2B2B2; bdat[1] = 32'hC3C3C3C3;
      bdat[2] = 32'hD4D4D4D4; bdat[3] = 32'hA1A1A1A1;
      burst(1, 1'b0, 14'h003C, 4'hF, 2'b01, 4);
      check_burst("wrap rd", 4, 2, 1'b1);

      // simultaneous reads: last grant was port 1, so port 0 leads
      dual_reads("rr", 6);

      // out-of-range write: err for one cycle at cycle 1, no ack
      set_port(0, 1'b1, 1'b1, 14'h3004, 32'h55555555, 4'hF, 3'b000, 2'b00);
      @(posedge clk); @(negedge clk);
      check("oor err cycle1", 32'(err), 32'd1);
      check("oor ack cycle1", 32'(ack), 32'd0);
      @(posedge clk); #1;
      set_port(0, 1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00);
      errs = 0;
      acks = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (err != 2'b00) errs++;
         if (ack != 2'b00) acks++;
      end
      check("oor err after", 32'(errs), 32'd0);
      check("oor ack after", 32'(acks), 32'd0);
      burst(1, 1'b0, 14'h2FFC, 4'hF, 2'b00, 1);
      check("oor intact top", brd[0], 32'hCAFEF00D);
      burst(1, 1'b0, 14'h0004, 4'hF, 2'b00, 1);
      check("oor intact low", brd[0], 32'h0BADF00D);

      // reset during beat 2 of a port-0 read burst
      set_port(0, 1'b1, 1'b0, 14'h0020, '0, 4'hF, 3'b010, 2'b00);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst beat1 ack", 32'(ack), 32'd1);
      check("rst beat1 data", dat_o[31:0], 32'd8);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst beat2 ack", 32'(ack), 32'd1);
      rst = 1'b1;
      #1;
      check("rst ack drop", 32'(ack), 32'd0);
      check("rst err drop", 32'(err), 32'd0);
      @(posedge clk); #1;
      set_port(0, 1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00);
      @(posedge clk); #1;
      rst = 1'b0;
      dual_reads("post rst", 1);
      for (int i = 0; i < 4; i++) bdat[i] = 32'(8 + i);
      burst(1, 1'b0, 14'h0020, 4'hF, 2'b00, 4);
      check_burst("post rst rd", 4, 2, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
